simple_adder_8bit: RTL and testbench
====================================

Name: simple_adder_8bit

Overview:
- 8-bit unsigned/two's-complement adder with carry-in, carry-out and status flags.
- Primary path is purely combinational: zero latency, ripple-carry built from per-bit full adders.
- A secondary registered copy of the result, with a valid strobe, lets downstream synchronous logic consume results one cycle later.
- Used as a leaf arithmetic block in datapaths; no internal state beyond the output register stage.

Parameters:
- WIDTH, 8, operand/result width in bits; all behaviour below is specified for 8, and RTL must stay correct for any WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock for the registered stage
- rst  input  1  synchronous, active-high reset; sampled on rising clk only
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in, weight 1
- in_valid  input  1  qualifies a/b/cin for capture into the registered stage
- sum  output  WIDTH  combinational (a + b + cin) mod 2^WIDTH
- cout  output  1  combinational carry out of the MSB
- overflow  output  1  combinational signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]
- zero  output  1  combinational, 1 when sum == 0
- sum_q  output  WIDTH  registered sum
- cout_q  output  1  registered cout
- overflow_q  output  1  registered overflow
- zero_q  output  1  registered zero
- out_valid  output  1  registered; 1 for the cycle after in_valid was sampled high

Behaviour:
- Combinational path:
  - {cout, sum} = a + b + cin, computed at WIDTH+1 bits, so the result never truncates.
  - Implemented as a ripple chain of WIDTH full adders. Bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i; c_0 = cin; cout = c_WIDTH.
  - No dependence on clk or rst.
  - Outputs settle within one clock period of any input change.
  - X/Z-free whenever inputs are 0/1.
- Flags:
  - overflow follows the signed rule above.
  - zero = ~|sum.
  - cout and overflow are independent. Example: 0xFF+0x01 gives cout=1, overflow=0. Example: 0x7F+0x01 gives cout=0, overflow=1.
- Registered path:
  - On rising clk with rst=1: sum_q=0, cout_q=0, overflow_q=0, zero_q=0, out_valid=0.
  - On rising clk with rst=0 and in_valid=1: capture sum, cout, overflow and zero; out_valid<=1.
  - On rising clk with rst=0 and in_valid=0: hold sum_q, cout_q, overflow_q and zero_q; out_valid<=0.
  - Latency is exactly 1 cycle from the sampling edge to registered outputs.
  - Throughput is one result per cycle; back-to-back in_valid is allowed.
  - There is no backpressure.
- Boundary conditions:
  - rst asserted mid-stream clears the registered outputs at the next edge and drops out_valid, even if in_valid=1 in the same cycle (reset wins).
  - The combinational outputs are unaffected by rst.
  - Full carry propagation (a=0xFF, b=0x00, cin=1) must ripple through all 8 bits: sum=0x00, cout=1.
  - Maximum case 0xFF+0xFF+1 = 0x1FF: sum=0xFF, cout=1.
  - Before the first reset, registered outputs are unspecified; benches must reset first.

Test Plan:
- a=00,b=00,cin=0 -> sum=00,cout=0,zero=1. Then cin=1 -> sum=01,cout=0,zero=0.
- a=FF,b=01,cin=0 -> sum=00,cout=1,zero=1,overflow=0. a=FF,b=00,cin=1 -> sum=00,cout=1 (full ripple).
- a=AA,b=55,cin=0 -> sum=FF,cout=0. a=33,b=CC,cin=1 -> sum=00,cout=1. a=FF,b=FF,cin=1 -> sum=FF,cout=1.
- a=7F,b=01,cin=0 -> sum=80,overflow=1,cout=0. a=80,b=80,cin=0 -> sum=00,overflow=1,cout=1,zero=1.
- Registered stage, after reset: in_valid=1 for 3 cycles with (01,01,0),(FF,01,1),(AA,55,0). Next 3 cycles must give out_valid=1 with sum_q=02,cout_q=0; then 01,1; then FF,0. With in_valid=0 afterwards, out_valid=0 and values hold.
- Assert rst=1 together with in_valid=1 (a=10,b=20). Next edge must give all registered outputs 0 and out_valid=0, while combinational sum=30 throughout. An exhaustive or random sweep must confirm {cout,sum}==a+b+cin on every vector.

Source files
------------

// File: rtl/simple_adder_8bit.sv
// rtl/simple_adder_8bit.sv - ripple-carry adder with flags and a one-cycle registered copy
module simple_adder_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             overflow_q,
  output logic             zero_q,
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  always_comb begin
    carry    = '0;
    sum_c    = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
  end

  assign sum      = sum_c;
  assign cout     = carry[WIDTH];
  // Signed overflow: like-signed operands produced a result of the other sign.
  assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
  assign zero     = ~|sum_c;

  logic [WIDTH-1:0] sum_q_d, sum_q_q;
  logic             cout_q_d, cout_q_q;
  logic             overflow_q_d, overflow_q_q;
  logic             zero_q_d, zero_q_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_q_d      = sum_q_q;
    cout_q_d     = cout_q_q;
    overflow_q_d = overflow_q_q;
    zero_q_d     = zero_q_q;
    out_valid_d  = 1'b0;
    if (in_valid) begin
      sum_q_d      = sum;
      cout_q_d     = cout;
      overflow_q_d = overflow;
      zero_q_d     = zero;
      out_valid_d  = 1'b1;
    end
  end

  // Reset takes priority over a simultaneous capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q_q      <= '0;
      cout_q_q     <= 1'b0;
      overflow_q_q <= 1'b0;
      zero_q_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      sum_q_q      <= sum_q_d;
      cout_q_q     <= cout_q_d;
      overflow_q_q <= overflow_q_d;
      zero_q_q     <= zero_q_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign sum_q      = sum_q_q;
  assign cout_q     = cout_q_q;
  assign overflow_q = overflow_q_q;
  assign zero_q     = zero_q_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_simple_adder_8bit.sv
// tb/tb_simple_adder_8bit.sv - scoreboard bench for simple_adder_8bit
module tb_simple_adder_8bit;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    res_t       r;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin, in_valid;
  logic [7:0] sum, sum_q;
  logic       cout, overflow, zero, cout_q, overflow_q, zero_q, out_valid;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  vec_t dir_tab[9];
  vec_t reg_tab[3];

  simple_adder_8bit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero),
    .sum_q(sum_q), .cout_q(cout_q), .overflow_q(overflow_q), .zero_q(zero_q),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
    res_t   r;
    int     wide;
    int     sx, sy, ss;
    wide = int'(x) + int'(y) + int'(c);
    sx   = (x > 8'd127) ? int'(x) - 256 : int'(x);
    sy   = (y > 8'd127) ? int'(y) - 256 : int'(y);
    ss   = sx + sy + int'(c);
    r.s  = wide[7:0];
    r.c  = wide[8];
    r.v  = (ss > 127) || (ss < -128);
    r.z  = (wide[7:0] == 8'h00);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_comb(input string name, input res_t e);
    check({name, " comb"}, {24'h0, sum, cout, overflow, zero}, {24'h0, e});
  endtask

  // Monitor: every out_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL reg_unexpected: out_valid=1 with no pending result, sum_q=%0h", sum_q);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        if ({sum_q, cout_q, overflow_q, zero_q} !== e) begin
          n_fail++;
          $display("FAIL reg_result: got sum_q=%0h cout_q=%0b ov_q=%0b zero_q=%0b, expected %0h %0b %0b %0b",
                   sum_q, cout_q, overflow_q, zero_q, e.s, e.c, e.v, e.z);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c, input logic v);
    @(posedge clk);
    #2;
    a = x; b = y; cin = c; in_valid = v;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_tab[0] = '{8'h00, 8'h00, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1}};
    dir_tab[1] = '{8'h00, 8'h00, 1'b1, '{8'h01, 1'b0, 1'b0, 1'b0}};
    dir_tab[2] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}};
    dir_tab[3] = '{8'hFF, 8'h00, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1}};
    dir_tab[4] = '{8'hAA, 8'h55, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0}};
    dir_tab[5] = '{8'h33, 8'hCC, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1}};
    dir_tab[6] = '{8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0}};
    dir_tab[7] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}};
    dir_tab[8] = '{8'h80, 8'h80, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b1}};
    reg_tab[0] = '{8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0, 1'b0}};
    reg_tab[1] = '{8'hFF, 8'h01, 1'b1, '{8'h01, 1'b1, 1'b0, 1'b0}};
    reg_tab[2] = '{8'hAA, 8'h55, 1'b0, '{8'hFF, 1'b0, 1'b0, 1'b0}};

    rst = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_state", {23'h0, sum_q, cout_q, overflow_q, zero_q, out_valid}, 32'h0);
    rst = 1'b0;

    // Directed vectors through both paths.
    foreach (dir_tab[i]) begin
      drive(dir_tab[i].a, dir_tab[i].b, dir_tab[i].ci, 1'b1);
      exp_q.push_back(dir_tab[i].r);
      #1;
      check_comb($sformatf("dir%0d", i), dir_tab[i].r);
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);

    // Back-to-back registered sequence, then hold.
    foreach (reg_tab[i]) begin
      drive(reg_tab[i].a, reg_tab[i].b, reg_tab[i].ci, 1'b1);
      exp_q.push_back(reg_tab[i].r);
    end
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    check("hold_valid", {31'h0, out_valid}, 32'h0);
    check("hold_value", {23'h0, sum_q, cout_q, overflow_q, zero_q}, {23'h0, 8'hFF, 3'b000});

    // Reset wins over a simultaneous capture; combinational path unaffected.
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_comb_before", {24'h0, sum}, 32'h30);
    @(posedge clk);
    #2;
    check("rst_wins", {23'h0, sum_q, cout_q, overflow_q, zero_q, out_valid}, 32'h0);
    check("rst_comb_after", {24'h0, sum}, 32'h30);
    rst = 1'b0; in_valid = 1'b0;

    // Random pipelined traffic with sporadic gaps.
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] x, y;
      logic       c, v;
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom); v = ($urandom_range(0, 3) != 0);
      drive(x, y, c, v);
      if (v) exp_q.push_back(model(x, y, c));
    end
    drive(8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 32'h0);

    // Exhaustive combinational sweep.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        for (int k = 0; k < 2; k++) begin
          a = 8'(i); b = 8'(j); cin = 1'(k);
          #1;
          n_checks++;
          if ({cout, sum} !== 9'(i + j + k)) begin
            n_fail++;
            $display("FAIL sweep %0h+%0h+%0d: got %0h, expected %0h", i, j, k, {cout, sum}, 9'(i + j + k));
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
